// File: rtl/fnd_scan_controller.sv
// Scan controller for a common-anode 4-digit 7-segment display: clamps a 14-bit
// value to 0..9999, converts it to BCD once per frame and multiplexes the digits.
module fnd_scan_controller #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter bit LZ_BLANK = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [13:0] i_value,
    input  logic        i_blank,
    input  logic [3:0]  i_dp_mask,
    output logic [3:0]  o_fndCom,
    output logic [7:0]  o_fndFont,
    output logic        o_convBusy
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int DW  = $clog2(DIV);
    localparam logic [DW-1:0] TERM = DW'(DIV - 1);

    // A digit slot must outlast a full 16-cycle conversion with margin.
    generate
        if (DIV < 32) begin : g_div_too_small
            $error("fnd_scan_controller: CLK_HZ/SCAN_HZ must be >= 32");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [1:0]    digit_idx;
    logic          frame_start;

    state_t        state;
    logic          start_pending;
    logic [13:0]   bin_sr;
    logic [15:0]   bcd_sr;
    logic [15:0]   bcd_adj;
    logic [3:0]    shift_cnt;
    logic [15:0]   disp_bcd;
    logic [13:0]   value_clamped;
    logic          unused_bcd_msb;

    logic [3:0]    cur_digit;
    logic          upper_zero;
    logic          digit_bad;
    logic [6:0]    seg_code;
    logic          dp_on;
    logic [3:0]    com_next;
    logic [7:0]    font_next;

    assign tick        = (div_cnt == TERM);
    assign frame_start = tick && (digit_idx == 2'd3);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div_cnt   <= '0;
            digit_idx <= 2'd0;
        end else if (tick) begin
            div_cnt   <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            div_cnt   <= div_cnt + DW'(1);
        end
    end

    assign value_clamped = (i_value > 14'd9999) ? 14'd9999 : i_value;

    always_comb begin
        bcd_adj = bcd_sr;
        for (int n = 0; n < 4; n++) begin
            if (bcd_sr[4*n +: 4] >= 4'd5) begin
                bcd_adj[4*n +: 4] = bcd_sr[4*n +: 4] + 4'd3;
            end
        end
    end

    // The clamp keeps the top BCD bit zero, so it is dropped by the shift.
    assign unused_bcd_msb = bcd_adj[15];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            start_pending <= 1'b1;
            bin_sr        <= '0;
            bcd_sr        <= '0;
            shift_cnt     <= '0;
            disp_bcd      <= '0;
            o_convBusy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_pending || frame_start) begin
                        state         <= LOAD;
                        start_pending <= 1'b0;
                        o_convBusy    <= 1'b1;
                    end
                end
                LOAD: begin
                    bin_sr    <= value_clamped;
                    bcd_sr    <= '0;
                    shift_cnt <= 4'd14;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj[14:0], bin_sr, 1'b0};
                    shift_cnt        <= shift_cnt - 4'd1;
                    if (shift_cnt == 4'd1) begin
                        state      <= DONE;
                        o_convBusy <= 1'b0;
                    end
                end
                DONE: begin
                    disp_bcd <= bcd_sr;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cur_digit = disp_bcd[{digit_idx, 2'b00} +: 4];
        dp_on     = i_dp_mask[digit_idx];
        case (digit_idx)
            2'd3:    upper_zero = (disp_bcd[15:12] == 4'd0);
            2'd2:    upper_zero = (disp_bcd[15:8] == 8'd0);
            2'd1:    upper_zero = (disp_bcd[15:4] == 12'd0);
            default: upper_zero = 1'b0;
        endcase
        digit_bad = 1'b0;
        case (cur_digit)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: begin
                seg_code  = 7'h7F;
                digit_bad = 1'b1;
            end
        endcase
        if (digit_bad) begin
            font_next = 8'hFF;
        end else if (LZ_BLANK && upper_zero) begin
            font_next = {~dp_on, 7'h7F};
        end else begin
            font_next = {~dp_on, seg_code};
        end
        com_next = i_blank ? 4'b1111 : ~(4'b0001 << digit_idx);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_fndCom  <= 4'b1111;
            o_fndFont <= 8'hFF;
        end else begin
            o_fndCom  <= com_next;
            o_fndFont <= font_next;
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: two instances (leading zeros shown / blanked)
// share stimulus; expected digit records flow through a queue per frame.
module tb_fnd_scan_controller;

    localparam int CYC_DIGIT = 32;
    localparam int CYC_FRAME = 4 * CYC_DIGIT;
    localparam int SAMPLE_AT = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] value;
    logic        blank;
    logic [3:0]  dp_mask;
    logic [3:0]  com0, com1;
    logic [7:0]  font0, font1;
    logic        busy0, busy1;

    always #5 clk = ~clk;

    fnd_scan_controller #(.CLK_HZ(3200), .SCAN_HZ(100), .LZ_BLANK(1'b0)) dut_lz0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_value(value), .i_blank(blank),
        .i_dp_mask(dp_mask), .o_fndCom(com0), .o_fndFont(font0), .o_convBusy(busy0)
    );

    fnd_scan_controller #(.CLK_HZ(3200), .SCAN_HZ(100), .LZ_BLANK(1'b1)) dut_lz1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_value(value), .i_blank(blank),
        .i_dp_mask(dp_mask), .o_fndCom(com1), .o_fndFont(font1), .o_convBusy(busy1)
    );

    // Bench-side cycle count since reset release: edge n shows digit ((n-1)/32)%4.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic [13:0] value;
        logic [3:0]  mask;
        logic [31:0] exp_lz0;
        logic [31:0] exp_lz1;
    } vec_t;

    vec_t        vecs[10];
    logic [19:0] exp_q[$];
    logic [7:0]  seg_tab[10];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          frame;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        int guard = 0;
        if (cyc > target) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_cyc: cycle %0d already past target %0d", cyc, target);
        end
        while (cyc < target && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_cyc: timeout at cycle %0d, target %0d", cyc, target);
        end
    endtask

    function automatic logic [31:0] model_fonts(input int v, input logic [3:0] mask, input bit lz);
        int          c;
        int          dig[4];
        bit          lead;
        logic [6:0]  seg;
        logic [31:0] r;
        c      = (v > 9999) ? 9999 : v;
        dig[0] = c % 10;
        dig[1] = (c / 10) % 10;
        dig[2] = (c / 100) % 10;
        dig[3] = (c / 1000) % 10;
        lead   = 1'b1;
        r      = '0;
        for (int k = 3; k >= 0; k--) begin
            lead = lead && (dig[k] == 0);
            seg  = (lz && lead && k > 0) ? 7'h7F : seg_tab[dig[k]][6:0];
            r[8*k +: 8] = {~mask[k], seg};
        end
        return r;
    endfunction

    task automatic push_frame(input logic [31:0] lz0, input logic [31:0] lz1);
        for (int d = 0; d < 4; d++) begin
            exp_q.push_back({~(4'b0001 << d), lz0[8*d +: 8], lz1[8*d +: 8]});
        end
    endtask

    task automatic sample_digit(input int f, input int d);
        logic [19:0] e;
        string       tag;
        wait_cyc(f * CYC_FRAME + d * CYC_DIGIT + SAMPLE_AT);
        tag = $sformatf("f%0d d%0d", f, d);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expected queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, " com lz0"}, 32'(com0), 32'(e[19:16]));
            check({tag, " com lz1"}, 32'(com1), 32'(e[19:16]));
            check({tag, " font lz0"}, 32'(font0), 32'(e[15:8]));
            check({tag, " font lz1"}, 32'(font1), 32'(e[7:0]));
        end
    endtask

    task automatic sample_frame(input int f);
        for (int d = 0; d < 4; d++) sample_digit(f, d);
    endtask

    // Starts right after reset release (cyc == 0) and walks cycles 1..20.
    task automatic post_reset_check(input string tag, input logic [7:0] exp_d0);
        int busy_cnt = 0;
        int first    = -1;
        int last     = -1;
        for (int n = 1; n <= 20; n++) begin
            wait_cyc(n);
            if (busy0) begin
                busy_cnt++;
                if (first < 0) first = n;
                last = n;
            end
            if (n == 17) check({tag, " digit0 before update"}, 32'(font0), 32'h0000_00C0);
            if (n == 18) begin
                check({tag, " digit0 after update"}, 32'(font0), 32'(exp_d0));
                check({tag, " com after update"}, 32'(com0), 32'h0000_000E);
            end
        end
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'd15);
        check({tag, " busy first"}, 32'(first), 32'd1);
        check({tag, " busy last"}, 32'(last), 32'd15);
    endtask

    task automatic apply_next_frame(input logic [13:0] v, input logic [3:0] m);
        wait_cyc(frame * CYC_FRAME - 2);
        value   = v;
        dp_mask = m;
    endtask

    initial begin
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        vecs[0] = '{14'd1234,  4'b0000, 32'hF9A4B099, 32'hF9A4B099};
        vecs[1] = '{14'd42,    4'b0000, 32'hC0C099A4, 32'hFFFF99A4};
        vecs[2] = '{14'd16383, 4'b0000, 32'h90909090, 32'h90909090};
        vecs[3] = '{14'd10000, 4'b0000, 32'h90909090, 32'h90909090};
        vecs[4] = '{14'd0,     4'b0000, 32'hC0C0C0C0, 32'hFFFFFFC0};
        vecs[5] = '{14'd1234,  4'b0100, 32'hF924B099, 32'hF924B099};
        vecs[6] = '{14'd5678,  4'b1001, 32'h1282F800, 32'h1282F800};
        vecs[7] = '{14'd705,   4'b0000, 32'hC0F8C092, 32'hFFF8C092};
        vecs[8] = '{14'd9999,  4'b1111, 32'h10101010, 32'h10101010};
        vecs[9] = '{14'd9,     4'b0010, 32'hC0C04090, 32'hFFFF7F90};

        rst_n   = 1'b0;
        value   = 14'd1234;
        blank   = 1'b0;
        dp_mask = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset com", 32'(com0), 32'h0000_000F);
        check("reset font", 32'(font0), 32'h0000_00FF);
        check("reset busy", 32'(busy0), 32'd0);
        check("reset font lz1", 32'(font1), 32'h0000_00FF);

        rst_n = 1'b1;
        post_reset_check("boot", 8'h99);
        push_frame(32'hF9A4B099, 32'hF9A4B099);
        sample_frame(0);

        // Value changes mid digit 1: rest of frame keeps 1234, next frame shows 0042.
        push_frame(32'hF9A4B099, 32'hF9A4B099);
        sample_digit(1, 0);
        wait_cyc(CYC_FRAME + CYC_DIGIT + 8);
        value = 14'd42;
        push_frame(32'hC0C099A4, 32'hFFFF99A4);
        for (int d = 1; d < 4; d++) sample_digit(1, d);
        sample_frame(2);
        frame = 3;

        for (int i = 0; i < 10; i++) begin
            apply_next_frame(vecs[i].value, vecs[i].mask);
            push_frame(vecs[i].exp_lz0, vecs[i].exp_lz1);
            sample_frame(frame);
            frame++;
        end

        for (int i = 0; i < 4; i++) begin
            logic [13:0] rv;
            logic [3:0]  rm;
            rv = 14'($urandom_range(0, 16383));
            rm = 4'($urandom_range(0, 15));
            apply_next_frame(rv, rm);
            push_frame(model_fonts(int'(rv), rm, 1'b0), model_fonts(int'(rv), rm, 1'b1));
            sample_frame(frame);
            frame++;
        end

        // Blank during digit 2, release during digit 3.
        apply_next_frame(14'd1234, 4'b0000);
        wait_cyc(frame * CYC_FRAME + 70);
        blank = 1'b1;
        wait_cyc(frame * CYC_FRAME + 71);
        check("blank com next cycle", 32'(com0), 32'h0000_000F);
        check("blank com lz1", 32'(com1), 32'h0000_000F);
        wait_cyc(frame * CYC_FRAME + 100);
        check("blank held digit3", 32'(com0), 32'h0000_000F);
        blank = 1'b0;
        wait_cyc(frame * CYC_FRAME + 101);
        check("unblank com", 32'(com0), 32'h0000_0007);
        check("unblank font", 32'(font0), 32'h0000_00F9);
        frame++;

        // Reset in the middle of SHIFT.
        apply_next_frame(14'd5678, 4'b0000);
        wait_cyc(frame * CYC_FRAME + 5);
        check("busy in shift", 32'(busy0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset com", 32'(com0), 32'h0000_000F);
        check("midreset font", 32'(font0), 32'h0000_00FF);
        check("midreset busy", 32'(busy0), 32'd0);
        check("midreset font lz1", 32'(font1), 32'h0000_00FF);
        @(negedge clk);
        rst_n = 1'b1;
        post_reset_check("rerun", 8'h80);
        push_frame(32'h9282F880, 32'h9282F880);
        sample_frame(0);

        check("queue drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
